rf_write_arbiter: RTL and testbench



---
 rtl/rf_pkg.sv | 18 +
 rtl/rr_age_picker.sv | 40 ++++
 rtl/rf_write_arbiter.sv | 104 ++++++++++
 tb/tb_rf_write_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file write arbiter.
package rf_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

  typedef struct packed {
    logic                  hv;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } holdEntry_t;

  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_age_picker.sv
// Round-robin picker over held entries, skipping any entry that has an older
// same-register entry flagged in the age matrix.
module rr_age_picker #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [ID_W-1:0] rrPtr,
  input  logic [NREQ-1:0] ageMat [NREQ],
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grantId
);

  logic [NREQ-1:0] blocked;
  logic [NREQ-1:0] ready;
  logic            found;
  int              idx;

  always_comb begin
    blocked = '0;
    grant   = '0;
    grantId = '0;
    found   = 1'b0;
    idx     = 0;
    // ageMat[j][i] set means j is an older write to the same register as i
    for (int j = 0; j < NREQ; j++)
      for (int i = 0; i < NREQ; i++)
        if (ageMat[j][i]) blocked[i] = 1'b1;
    ready = eligible & ~blocked;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rrPtr) + k) % NREQ;
      if (!found && ready[idx]) begin
        grant[idx] = 1'b1;
        grantId    = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between NREQ writeback sources.
// Define RF_ARB_SCOREBOARD_EN to drive the pending-write scoreboard output.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter  int NREQ   = 2,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int ADDR_W = ADDR_W_DEF,
  localparam int ID_W   = idWidth(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic [ID_W-1:0]        grant_id,
  output logic [2**ADDR_W-1:0]   pending
);

  holdEntry_t      hold [NREQ];
  logic [NREQ-1:0] older [NREQ];     // older[i][j]: entry i was accepted before entry j
  logic [NREQ-1:0] blockAge [NREQ];
  logic [NREQ-1:0] held, grant, accept, stayHeld;
  logic [ID_W-1:0] rrPtr, grantId;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      held[i] = hold[i].hv;
      for (int j = 0; j < NREQ; j++)
        blockAge[j][i] = older[j][i] && hold[j].hv && (hold[j].addr == hold[i].addr);
    end
  end

  rr_age_picker #(.NREQ(NREQ), .ID_W(ID_W)) uPicker (
    .eligible (held),
    .rrPtr    (rrPtr),
    .ageMat   (blockAge),
    .grant    (grant),
    .grantId  (grantId)
  );

  assign req_ready = ~held | grant;
  assign accept    = req_valid & req_ready;
  assign stayHeld  = held & ~grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        hold[i]  <= '0;
        older[i] <= '0;
      end
      rrPtr <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i])
          hold[i] <= '{hv: 1'b1,
                       addr: req_addr[i*ADDR_W +: ADDR_W],
                       data: req_data[i*DATA_W +: DATA_W]};
        else if (grant[i])
          hold[i].hv <= 1'b0;
      end
      // A newly accepted entry is younger than everything still held; entries
      // accepted on the same edge stay unordered.
      for (int i = 0; i < NREQ; i++)
        for (int j = 0; j < NREQ; j++)
          if (i == j)
            older[i][j] <= 1'b0;
          else if (accept[j])
            older[i][j] <= stayHeld[i];
          else if (accept[i] || !stayHeld[i] || !stayHeld[j])
            older[i][j] <= 1'b0;
      if (|grant)
        rrPtr <= (grantId == ID_W'(NREQ - 1)) ? '0 : grantId + ID_W'(1);
    end
  end

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) begin
        wr_addr = hold[i].addr;
        wr_data = hold[i].data;
      end
  end

  assign wr_en    = |grant;
  assign grant_id = grantId;

`ifdef RF_ARB_SCOREBOARD_EN
  always_comb begin
    pending = '0;
    for (int i = 0; i < NREQ; i++)
      if (hold[i].hv) pending[hold[i].addr] = 1'b1;
  end
`else
  assign pending = '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed plus randomized bench for rf_write_arbiter against a timestamp-based model.
module tb_rf_write_arbiter;

`ifdef RF_ARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        grant_id;
  logic [15:0] pending;

  rf_write_arbiter #(.NREQ(2), .DATA_W(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file fed by the arbiter's write port
  logic [15:0] tbRf [16];
  int          rfWrites = 0;
  always @(posedge clk)
    if (wr_en) begin
      tbRf[wr_addr] <= wr_data;
      rfWrites      <= rfWrites + 1;
    end

  int checks = 0;
  int errors = 0;

  // model: each held write carries the edge number it was accepted on
  bit          mv [2];
  logic [3:0]  ma [2];
  logic [15:0] md [2];
  int          ms [2];
  int          mptr   = 0;
  int          edgeNo = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int modelPick();
    int best = -1;
    for (int k = 0; k < 2; k++) begin
      int  i   = (mptr + k) % 2;
      bit  blk = 1'b0;
      if (mv[i]) begin
        for (int j = 0; j < 2; j++)
          if (j != i && mv[j] && ma[j] == ma[i] && ms[j] < ms[i]) blk = 1'b1;
        if (!blk && best < 0) best = i;
      end
    end
    return best;
  endfunction

  // Called at a negedge: drive inputs, check state-derived outputs, advance one edge.
  task automatic step(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1, input logic r);
    int          g;
    logic [1:0]  rdy;
    logic [15:0] pend;
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    rst       = r;
    g    = modelPick();
    pend = '0;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = !mv[i] || (g == i);
      if (mv[i] && SB) pend[ma[i]] = 1'b1;
    end
    chk("wr_en", wr_en, (g >= 0));
    chk("wr_addr", wr_addr, (g >= 0) ? ma[g] : 4'h0);
    chk("wr_data", wr_data, (g >= 0) ? md[g] : 16'h0);
    chk("grant_id", grant_id, (g >= 0) ? g[0] : 1'b0);
    chk("req_ready", req_ready, rdy);
    chk("pending", pending, pend);
    @(posedge clk);
    if (r) begin
      mv[0] = 1'b0;
      mv[1] = 1'b0;
      mptr  = 0;
    end else begin
      if (g >= 0) begin
        mv[g] = 1'b0;
        mptr  = (g + 1) % 2;
      end
      for (int i = 0; i < 2; i++)
        if (v[i] && rdy[i]) begin
          mv[i] = 1'b1;
          ma[i] = (i == 0) ? a0 : a1;
          md[i] = (i == 0) ? d0 : d1;
          ms[i] = edgeNo;
        end
    end
    edgeNo++;
    @(negedge clk);
  endtask

  task automatic idle();
    step(2'b00, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic doReset();
    step(2'b00, 4'h0, 4'h0, 16'h0, 16'h0, 1'b1);
  endtask

  initial begin
    int w;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    mv[0] = 1'b0;
    mv[1] = 1'b0;
    @(negedge clk);
    doReset();
    doReset();
    chk("reset_wr_en", wr_en, 1'b0);
    chk("reset_ready", req_ready, 2'b11);
    chk("reset_gid", grant_id, 1'b0);
    chk("reset_pending", pending, 16'h0);

    // single write
    step(2'b01, 4'd3, 4'd0, 16'hBEEF, 16'h0, 1'b0);
    chk("single_en", wr_en, 1'b1);
    chk("single_addr", wr_addr, 4'd3);
    chk("single_data", wr_data, 16'hBEEF);
    chk("single_ready0", req_ready[0], 1'b1);
    idle();
    chk("single_rf3", tbRf[3], 16'hBEEF);

    // fairness
    doReset();
    for (int k = 0; k < 6; k++) begin
      step(2'b11, 4'd1, 4'd2, 16'(100 + k), 16'(200 + k), 1'b0);
      chk("fair_gid", grant_id, k[0]);
      chk("fair_ready", req_ready, k[0] ? 2'b10 : 2'b01);
    end

    // same-register ordering and backpressure
    doReset();
    step(2'b11, 4'd8, 4'd5, 16'hAAAA, 16'h0001, 1'b0);
    chk("order_first_gid", grant_id, 1'b0);
    step(2'b01, 4'd5, 4'd0, 16'h0002, 16'h0, 1'b0);
    chk("order_old_gid", grant_id, 1'b1);
    chk("order_old_data", wr_data, 16'h0001);
    chk("bp_ready", req_ready, 2'b10);
    step(2'b01, 4'd5, 4'd0, 16'h0002, 16'h0, 1'b0);
    chk("order_young_gid", grant_id, 1'b0);
    chk("order_young_data", wr_data, 16'h0002);
    idle();
    chk("order_rf5", tbRf[5], 16'h0002);

    // reset mid-operation
    step(2'b11, 4'd6, 4'd6, 16'h1111, 16'h2222, 1'b0);
    step(2'b11, 4'd6, 4'd6, 16'h3333, 16'h4444, 1'b0);
    step(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1);
    chk("midrst_wr_en", wr_en, 1'b0);
    chk("midrst_ready", req_ready, 2'b11);
    chk("midrst_pending", pending, 16'h0);
    w = rfWrites;
    idle();
    idle();
    idle();
    chk("midrst_no_writes", rfWrites, w);

    // scoreboard: two in-flight writes to r7
    step(2'b11, 4'd7, 4'd7, 16'h0070, 16'h0071, 1'b0);
    chk("sb_pend7_both", pending[7], SB);
    idle();
    chk("sb_pend7_one", pending[7], SB);
    idle();
    chk("sb_pend7_drained", pending[7], 1'b0);

    // randomized traffic with narrow addresses to force conflicts
    for (int n = 0; n < 400; n++)
      step(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           16'($urandom), 16'($urandom), ($urandom_range(0, 63) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
